// File: rtl/rx_pkg.sv
// Shared types and constants for the serial Rx alignment front-end.
package rx_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned BYTE_W   = 8;

  localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    StSearch,
    StLocking,
    StSync
  } state_e;

endpackage

// File: rtl/comma_detect_shift.sv
// Serial-in byte window: exposes the byte formed by the incoming bit and flags a comma.
module comma_detect_shift
  import rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA = COMMA_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bit_i,
  output logic [BYTE_W-1:0] next_byte_o,
  output logic              is_comma_o
);

  logic [BYTE_W-1:0] sr_q;

  assign next_byte_o = {sr_q[BYTE_W-2:0], bit_i};
  assign is_comma_o  = (next_byte_o == COMMA);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= next_byte_o;
    end
  end

endmodule

// File: rtl/serial_to_nibble_aligner.sv
// Comma-based byte aligner; once synced, emits each byte as high then low nibble on a 4-cycle strobe.
module serial_to_nibble_aligner
  import rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COMMA       = COMMA_DEFAULT,
  parameter int unsigned       COMMA_COUNT = 4
) (
  input  logic                clk_8f,
  input  logic                reset,
  input  logic                data_in,
  output logic [NIBBLE_W-1:0] data_out,
  output logic                valid_out,
  output logic                nibble_stb,
  output logic                active_out
);

  logic [BYTE_W-1:0] next_byte;
  logic              is_comma;

  state_e            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        comma_cnt_q, comma_cnt_d;
  logic [NIBBLE_W-1:0] data_q, data_d;
  logic [NIBBLE_W-1:0] lo_data_q, lo_data_d;
  logic              valid_q, valid_d;
  logic              lo_valid_q, lo_valid_d;
  logic              stb_q, stb_d;
  logic              active_q, active_d;
  logic              half_q, half_d;
  logic              byte_done;

  comma_detect_shift #(
    .COMMA(COMMA)
  ) u_shift (
    .clk_i      (clk_8f),
    .rst_i      (reset),
    .bit_i      (data_in),
    .next_byte_o(next_byte),
    .is_comma_o (is_comma)
  );

  assign byte_done = (state_q != StSearch) && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q     <= StSearch;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      data_q      <= '0;
      lo_data_q   <= '0;
      valid_q     <= 1'b0;
      lo_valid_q  <= 1'b0;
      stb_q       <= 1'b0;
      active_q    <= 1'b0;
      half_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      data_q      <= data_d;
      lo_data_q   <= lo_data_d;
      valid_q     <= valid_d;
      lo_valid_q  <= lo_valid_d;
      stb_q       <= stb_d;
      active_q    <= active_d;
      half_q      <= half_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    unique case (state_q)
      StSearch: begin
        bit_cnt_d = '0;
        if (is_comma) begin
          comma_cnt_d = 4'd1;
          state_d     = StLocking;
        end
      end
      StLocking: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_q + 4'd1 == 4'(COMMA_COUNT)) begin
              state_d = StSync;
            end
          end else begin
            // Hunt resumes from the bit after the rejected byte.
            comma_cnt_d = '0;
            bit_cnt_d   = '0;
            state_d     = StSearch;
          end
        end
      end
      StSync: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      default: begin
        state_d = StSearch;
      end
    endcase
  end

  // The comma that completes the lock count already occupies the first nibble slots.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    lo_data_d  = lo_data_q;
    lo_valid_d = lo_valid_q;
    half_d     = half_q;
    stb_d      = 1'b0;
    active_d   = (state_d == StSync);
    if (byte_done && (state_d == StSync)) begin
      data_d     = is_comma ? '0 : next_byte[BYTE_W-1:NIBBLE_W];
      lo_data_d  = is_comma ? '0 : next_byte[NIBBLE_W-1:0];
      valid_d    = ~is_comma;
      lo_valid_d = ~is_comma;
      stb_d      = 1'b1;
      half_d     = 1'b0;
    end else if ((state_q == StSync) && (bit_cnt_q == 3'd3) && !half_q) begin
      data_d  = lo_data_q;
      valid_d = lo_valid_q;
      stb_d   = 1'b1;
      half_d  = 1'b1;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign nibble_stb = stb_q;
  assign active_out = active_q;

endmodule
